// File: rtl/harris_pkg.sv
// Shared types and defaults for the Harris 3x3 window buffer.
package harris_pkg;

    localparam int DATA_W_DEF = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/harris_window_buffer_if.sv
// Pixel stream in, 3x3 window taps out; the buffer is the slave, the source/sink is the master.
interface harris_window_buffer_if #(
    parameter int DATA_W = harris_pkg::DATA_W_DEF
);
    logic                     in_valid;
    logic                     in_sof;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     frame_done;
    logic signed [DATA_W-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_valid, frame_done,
        input  win0, win1, win2, win3, win4, win5, win6, win7, win8
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_valid, frame_done,
        output win0, win1, win2, win3, win4, win5, win6, win7, win8
    );
endinterface

// File: rtl/harris_line_buffer.sv
// One-row delay line: one write and one registered read per enabled cycle, block-RAM friendly.
module harris_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 40,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic signed [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]           rd_addr_i,
    output logic signed [WIDTH-1:0] rd_data_o
);
    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic signed [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
            rd_data_q        <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/harris_window_buffer.sv
// Raster pixel stream to registered 3x3 neighbourhood for the Harris response stage.
//   state | meaning
//   IDLE  | waiting for in_sof, all other input ignored
//   FILL  | rows 0..1, priming the line buffers
//   RUN   | rows 2..IMG_H-1, windows emitted from column 2 on
module harris_window_buffer
    import harris_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input logic                   clk,
    input logic                   rst_n,
    harris_window_buffer_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef logic signed [DATA_W-1:0] pix_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, cur_col, rd_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          sof, accept, col_wrap, last_pix, emit;
    logic          out_valid_q, out_valid_d, frame_done_q, frame_done_d;
    pix_t          lb1_rd, lb2_rd;
    pix_t          prime_q [6];
    pix_t          prime_d [6];
    pix_t          win_q [9];
    pix_t          win_d [9];

    assign sof      = bus.in_valid && bus.in_sof;
    assign accept   = bus.in_valid && (bus.in_sof || state_q != IDLE);
    assign cur_col  = sof ? '0 : col_q;
    assign cur_row  = sof ? '0 : row_q;
    assign col_wrap = cur_col == COL_LAST;
    assign last_pix = col_wrap && cur_row == ROW_LAST;
    assign emit     = accept && cur_row >= RW'(2) && cur_col >= CW'(2);
    // Read one column ahead so the registered RAM output is ready at the next accepted pixel.
    assign rd_col   = col_wrap ? '0 : cur_col + CW'(1);

    harris_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb_r1 (
        .clk       (clk),
        .en_i      (accept),
        .wr_addr_i (cur_col),
        .wr_data_i (bus.in_data),
        .rd_addr_i (rd_col),
        .rd_data_o (lb1_rd)
    );

    harris_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb_r2 (
        .clk       (clk),
        .en_i      (accept),
        .wr_addr_i (cur_col),
        .wr_data_i (lb1_rd),
        .rd_addr_i (rd_col),
        .rd_data_o (lb2_rd)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        prime_d      = prime_q;
        win_d        = win_q;
        out_valid_d  = emit;
        frame_done_d = accept && last_pix;

        if (accept) begin
            col_d      = col_wrap ? '0 : cur_col + CW'(1);
            row_d      = col_wrap ? (last_pix ? '0 : cur_row + RW'(1)) : cur_row;
            prime_d[0] = prime_q[1];
            prime_d[1] = lb2_rd;
            prime_d[2] = prime_q[3];
            prime_d[3] = lb1_rd;
            prime_d[4] = prime_q[5];
            prime_d[5] = bus.in_data;
        end

        // Output taps load only on a full neighbourhood so they hold between pulses.
        if (emit) begin
            win_d = '{prime_q[0], prime_q[1], lb2_rd,
                      prime_q[2], prime_q[3], lb1_rd,
                      prime_q[4], prime_q[5], bus.in_data};
        end

        case (state_q)
            IDLE:    if (sof) state_d = FILL;
            FILL:    if (sof) state_d = FILL;
                     else if (accept && col_wrap && cur_row == RW'(1)) state_d = RUN;
            RUN:     if (sof) state_d = FILL;
                     else if (accept && last_pix) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            prime_q      <= '{default: '0};
            win_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            prime_q      <= prime_d;
            win_q        <= win_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.win0 = win_q[0];
    assign bus.win1 = win_q[1];
    assign bus.win2 = win_q[2];
    assign bus.win3 = win_q[3];
    assign bus.win4 = win_q[4];
    assign bus.win5 = win_q[5];
    assign bus.win6 = win_q[6];
    assign bus.win7 = win_q[7];
    assign bus.win8 = win_q[8];
endmodule

// File: tb/tb_harris_window_buffer.sv
// Directed and randomized pixel streams checked against an image-array reference model.
module tb_harris_window_buffer;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 40;
    localparam int VW = 9 * DW;

    typedef logic [VW-1:0] vec_t;
    typedef logic signed [DW-1:0] pix_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    harris_window_buffer_if #(.DATA_W(DW)) bus ();

    harris_window_buffer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pix_t img [H][W];
    bit   m_active;
    int   m_row, m_col;
    vec_t m_win;
    bit   exp_ov, exp_fd;
    int   passed, total, pulses;
    vec_t first_win;

    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic vec_t taps();
        return {bus.win0, bus.win1, bus.win2, bus.win3, bus.win4,
                bus.win5, bus.win6, bus.win7, bus.win8};
    endfunction

    function automatic pix_t rand_pix();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    function automatic pix_t raster_val(input int idx);
        return pix_t'((idx / W) * 16 + (idx % W));
    endfunction

    // Reference: place each accepted pixel at its (row,col) and read the 3x3 block ending there.
    task automatic model_step(input bit v, input bit s, input pix_t d);
        exp_ov = 1'b0;
        exp_fd = 1'b0;
        if (v && s) begin
            m_active = 1'b1;
            m_row = 0;
            m_col = 0;
        end
        if (v && m_active) begin
            img[m_row][m_col] = d;
            if (m_row >= 2 && m_col >= 2) begin
                exp_ov = 1'b1;
                for (int i = 0; i < 9; i++)
                    m_win[(8 - i) * DW +: DW] = img[m_row - 2 + i / 3][m_col - 2 + i % 3];
            end
            exp_fd = (m_row == H - 1) && (m_col == W - 1);
            if (m_col == W - 1) begin
                m_col = 0;
                if (m_row == H - 1) begin
                    m_row = 0;
                    m_active = 1'b0;
                end else m_row++;
            end else m_col++;
        end
    endtask

    task automatic drive(input bit v, input bit s, input pix_t d);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_data  = d;
        @(posedge clk);
        model_step(v, s, d);
        #1;
        check("out_valid", VW'(bus.out_valid), VW'(exp_ov));
        check("frame_done", VW'(bus.frame_done), VW'(exp_fd));
        check("taps", taps(), m_win);
        if (bus.out_valid) begin
            if (pulses == 0) first_win = taps();
            pulses++;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst_n = 1'b0;
        #3;
        m_active = 1'b0;
        m_win    = '0;
        check("rst_out_valid", VW'(bus.out_valid), VW'(0));
        check("rst_frame_done", VW'(bus.frame_done), VW'(0));
        check("rst_taps", taps(), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // gap_mode: 0 contiguous, 1 alternate cycles, 2 random gaps
    task automatic send_pixels(input int n, input int first_idx, input bit sof_first,
                               input int gap_mode, input bit rnd);
        for (int k = 0; k < n; k++) begin
            if (gap_mode == 1) drive(1'b0, 1'b0, rand_pix());
            if (gap_mode == 2) begin
                int g = ($urandom_range(3) == 0) ? int'($urandom_range(4, 1)) : 0;
                for (int j = 0; j < g; j++) drive(1'b0, $urandom_range(1) == 1, rand_pix());
            end
            drive(1'b1, sof_first && k == 0, rnd ? rand_pix() : raster_val(first_idx + k));
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        m_win  = '0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        apply_reset();

        pulses = 0;
        send_pixels(W * H, 0, 1'b1, 0, 1'b0);
        check("contig_pulses", VW'(pulses), VW'(24));
        check("first_win_0_4_8", VW'({first_win[8*DW +: DW], first_win[4*DW +: DW], first_win[0 +: DW]}),
              VW'({pix_t'(0), pix_t'('h11), pix_t'('h22)}));
        drive(1'b1, 1'b0, pix_t'('h99));

        pulses = 0;
        send_pixels(W * H, 0, 1'b1, 1, 1'b0);
        check("alt_pulses", VW'(pulses), VW'(24));

        send_pixels(28, 0, 1'b1, 0, 1'b0);
        pulses = 0;
        send_pixels(W * H, 28, 1'b1, 0, 1'b0);
        check("restart_pulses", VW'(pulses), VW'(24));

        send_pixels(20, 0, 1'b1, 0, 1'b0);
        apply_reset();
        pulses = 0;
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, rand_pix());
        check("post_rst_pulses", VW'(pulses), VW'(0));

        for (int f = 0; f < 8; f++) begin
            send_pixels(int'($urandom_range(W * H, 1)), 0, 1'b1, 2, 1'b1);
            if (f % 3 == 2) apply_reset();
        end
        pulses = 0;
        send_pixels(W * H, 0, 1'b1, 2, 1'b1);
        check("rand_pulses", VW'(pulses), VW'(24));
        drive(1'b1, 1'b0, rand_pix());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
